// File: rtl/tpu_ctrl_pkg.sv
// Shared control-path types for the TPU instruction interface: instruction bit
// positions, program entry layout and sequencer state encoding.
package tpu_ctrl_pkg;

  localparam int INSTR_W      = 6;
  localparam int SEQ_REP_W    = 4;

  localparam int ACT_LO       = 0;
  localparam int ACT_HI       = 1;
  localparam int NN_START     = 2;
  localparam int LOAD_INPUTS  = 3;
  localparam int LOAD_WEIGHTS = 4;
  localparam int LOAD_BIAS    = 5;

  localparam logic [INSTR_W-1:0] INSTR_NOP = '0;

  typedef struct packed {
    logic                 halt;
    logic [SEQ_REP_W-1:0] rep;
    logic [INSTR_W-1:0]   instr;
  } prog_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

endpackage

// File: rtl/seq_prog_mem.sv
// Program store for the instruction sequencer: synchronous write, two
// combinational read ports (current entry and the one after it).
module seq_prog_mem
  import tpu_ctrl_pkg::*;
#(
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  prog_entry_t       wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output prog_entry_t       rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output prog_entry_t       rdata_b
);

  // Contents are deliberately left unreset so a reset does not wipe a loaded program.
  prog_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/instruction_sequencer.sv
// Steps through the program store and issues one 6-bit control instruction per
// cycle to the control decoder, honouring per-entry repeats, halt, stall and abort.
module instruction_sequencer
  import tpu_ctrl_pkg::*;
#(
  parameter  int DEPTH  = 16,
  parameter  int REP_W  = SEQ_REP_W,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_instr,
  input  logic [REP_W-1:0]   prog_rep,
  input  logic               prog_halt,
  input  logic               start,
  input  logic               stall,
  input  logic               abort,
  output logic [INSTR_W-1:0] instruction,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  pc
);

  seq_state_t         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [REP_W-1:0]   cnt_q, cnt_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               fresh_q, fresh_d;

  prog_entry_t        wr_entry;
  prog_entry_t        cur_entry;
  prog_entry_t        nxt_entry;
  logic [ADDR_W-1:0]  pc_nxt;
  logic               is_terminal;

  assign wr_entry    = '{halt: prog_halt, rep: SEQ_REP_W'(prog_rep), instr: prog_instr};
  assign pc_nxt      = pc_q + ADDR_W'(1);
  assign is_terminal = cur_entry.halt || (pc_q == ADDR_W'(DEPTH - 1));

  seq_prog_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clk    (clk),
    .we     (prog_we && (state_q == IDLE)),
    .waddr  (prog_addr),
    .wdata  (wr_entry),
    .raddr_a(pc_q),
    .rdata_a(cur_entry),
    .raddr_b(pc_nxt),
    .rdata_b(nxt_entry)
  );

  // fresh_q marks an entry that was loaded under stall and has not yet been
  // shown once; its first emission must not consume a repeat.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    fresh_d = fresh_q;
    case (state_q)
      IDLE: begin
        instr_d = INSTR_NOP;
        busy_d  = 1'b0;
        pc_d    = '0;
        cnt_d   = '0;
        fresh_d = 1'b0;
        if (start && !abort) begin
          state_d = RUN;
          busy_d  = 1'b1;
          cnt_d   = REP_W'(cur_entry.rep);
          instr_d = stall ? INSTR_NOP : cur_entry.instr;
          fresh_d = stall;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          instr_d = INSTR_NOP;
          pc_d    = '0;
          cnt_d   = '0;
          fresh_d = 1'b0;
        end else if (stall) begin
          instr_d = INSTR_NOP;
        end else if (fresh_q) begin
          instr_d = cur_entry.instr;
          fresh_d = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d   = cnt_q - REP_W'(1);
          instr_d = cur_entry.instr;
        end else if (is_terminal) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          instr_d = INSTR_NOP;
          pc_d    = '0;
        end else begin
          pc_d    = pc_nxt;
          cnt_d   = REP_W'(nxt_entry.rep);
          instr_d = nxt_entry.instr;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      instr_q <= INSTR_NOP;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fresh_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fresh_q <= fresh_d;
    end
  end

  assign instruction = instr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pc          = pc_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed scoreboard bench for instruction_sequencer: each stimulus step queues
// the hand-derived outputs expected after the next clock edge.
module tb_instruction_sequencer;
  import tpu_ctrl_pkg::*;

  localparam int DEPTH  = 16;
  localparam int REP_W  = 4;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              prog_we = 1'b0;
  logic [ADDR_W-1:0] prog_addr = '0;
  logic [5:0]        prog_instr = '0;
  logic [REP_W-1:0]  prog_rep = '0;
  logic              prog_halt = 1'b0;
  logic              start = 1'b0;
  logic              stall = 1'b0;
  logic              abort = 1'b0;
  logic [5:0]        instruction;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] pc;

  always #5 clk = ~clk;

  instruction_sequencer #(
    .DEPTH(DEPTH),
    .REP_W(REP_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_instr (prog_instr),
    .prog_rep   (prog_rep),
    .prog_halt  (prog_halt),
    .start      (start),
    .stall      (stall),
    .abort      (abort),
    .instruction(instruction),
    .busy       (busy),
    .done       (done),
    .pc         (pc)
  );

  typedef struct packed {
    logic [5:0]        instr;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] pc;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    total = 0;
  int    bad = 0;
  obs_t  mon_e;
  obs_t  mon_a;
  string mon_t;

  // Monitor: one expectation is consumed per falling edge, away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      mon_a = '{instruction, busy, done, pc};
      total++;
      if (mon_a !== mon_e) begin
        bad++;
        $display("FAIL %s: got instr=%h busy=%b done=%b pc=%0d, want instr=%h busy=%b done=%b pc=%0d",
                 mon_t, mon_a.instr, mon_a.busy, mon_a.done, mon_a.pc,
                 mon_e.instr, mon_e.busy, mon_e.done, mon_e.pc);
      end
    end
  end

  task automatic expect_obs(input string t, input logic [5:0] ei, input logic eb,
                            input logic ed, input int ep);
    exp_q.push_back('{ei, eb, ed, ADDR_W'(ep)});
    tag_q.push_back(t);
  endtask

  // Called just after a falling edge; outputs are checked at the next falling edge.
  task automatic cyc(input string t, input logic s, input logic st, input logic ab,
                     input logic [5:0] ei, input logic eb, input logic ed, input int ep);
    start = s;
    stall = st;
    abort = ab;
    expect_obs(t, ei, eb, ed, ep);
    @(negedge clk);
    #1;
    start = 1'b0;
    stall = 1'b0;
    abort = 1'b0;
  endtask

  task automatic idle(input string t);
    cyc(t, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 0);
  endtask

  task automatic wr(input int a, input logic h, input int r, input logic [5:0] ins);
    prog_we    = 1'b1;
    prog_addr  = ADDR_W'(a);
    prog_halt  = h;
    prog_rep   = REP_W'(r);
    prog_instr = ins;
    idle("write_idle");
    prog_we = 1'b0;
  endtask

  task automatic load_base();
    wr(0, 1'b0, 0, 6'h08);
    wr(1, 1'b0, 2, 6'h10);
    wr(2, 1'b1, 0, 6'h24);
  endtask

  task automatic run_base(input string t);
    cyc({t, "_e0"},   1'b1, 1'b0, 1'b0, 6'h08, 1'b1, 1'b0, 0);
    cyc({t, "_e1a"},  1'b0, 1'b0, 1'b0, 6'h10, 1'b1, 1'b0, 1);
    cyc({t, "_e1b"},  1'b0, 1'b0, 1'b0, 6'h10, 1'b1, 1'b0, 1);
    cyc({t, "_e1c"},  1'b0, 1'b0, 1'b0, 6'h10, 1'b1, 1'b0, 1);
    cyc({t, "_e2"},   1'b0, 1'b0, 1'b0, 6'h24, 1'b1, 1'b0, 2);
    cyc({t, "_done"}, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 0);
    idle({t, "_after"});
  endtask

  initial begin
    @(negedge clk);
    #1;
    cyc("reset_hold", 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 0);
    rst_n = 1'b1;
    idle("reset_release");

    load_base();
    run_base("basic");

    // Stall for three cycles while entry 1 has one repeat left; a start mid-run is ignored.
    cyc("stall_e0",   1'b1, 1'b0, 1'b0, 6'h08, 1'b1, 1'b0, 0);
    cyc("stall_e1a",  1'b1, 1'b0, 1'b0, 6'h10, 1'b1, 1'b0, 1);
    cyc("stall_e1b",  1'b0, 1'b0, 1'b0, 6'h10, 1'b1, 1'b0, 1);
    for (int k = 0; k < 3; k++)
      cyc("stall_nop", 1'b0, 1'b1, 1'b0, 6'h00, 1'b1, 1'b0, 1);
    cyc("stall_e1c",  1'b0, 1'b0, 1'b0, 6'h10, 1'b1, 1'b0, 1);
    cyc("stall_e2",   1'b0, 1'b0, 1'b0, 6'h24, 1'b1, 1'b0, 2);
    cyc("stall_done", 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 0);
    idle("stall_after");

    // Abort on the second cycle of entry 1.
    cyc("abort_e0",   1'b1, 1'b0, 1'b0, 6'h08, 1'b1, 1'b0, 0);
    cyc("abort_e1a",  1'b0, 1'b0, 1'b0, 6'h10, 1'b1, 1'b0, 1);
    cyc("abort_e1b",  1'b0, 1'b0, 1'b0, 6'h10, 1'b1, 1'b0, 1);
    cyc("abort_hit",  1'b0, 1'b0, 1'b1, 6'h00, 1'b0, 1'b0, 0);
    idle("abort_nodone1");
    idle("abort_nodone2");

    // Abort in IDLE is inert; start with abort stays IDLE.
    cyc("idle_abort",       1'b0, 1'b0, 1'b1, 6'h00, 1'b0, 1'b0, 0);
    cyc("start_with_abort", 1'b1, 1'b0, 1'b1, 6'h00, 1'b0, 1'b0, 0);
    idle("start_abort_after");

    // Start under stall enters RUN but shows NOP until stall drops.
    cyc("ss_start", 1'b1, 1'b1, 1'b0, 6'h00, 1'b1, 1'b0, 0);
    cyc("ss_hold",  1'b0, 1'b1, 1'b0, 6'h00, 1'b1, 1'b0, 0);
    cyc("ss_e0",    1'b0, 1'b0, 1'b0, 6'h08, 1'b1, 1'b0, 0);
    cyc("ss_e1a",   1'b0, 1'b0, 1'b0, 6'h10, 1'b1, 1'b0, 1);
    cyc("ss_e1b",   1'b0, 1'b0, 1'b0, 6'h10, 1'b1, 1'b0, 1);
    cyc("ss_e1c",   1'b0, 1'b0, 1'b0, 6'h10, 1'b1, 1'b0, 1);
    cyc("ss_e2",    1'b0, 1'b0, 1'b0, 6'h24, 1'b1, 1'b0, 2);
    cyc("ss_done",  1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 0);
    idle("ss_after");

    // Full-depth program with no halt bits: implicit stop at the last address.
    for (int i = 0; i < DEPTH; i++)
      wr(i, 1'b0, 0, 6'h10 + 6'(i));
    cyc("full_pc0", 1'b1, 1'b0, 1'b0, 6'h10, 1'b1, 1'b0, 0);
    for (int i = 1; i < DEPTH; i++)
      cyc("full_step", 1'b0, 1'b0, 1'b0, 6'h10 + 6'(i), 1'b1, 1'b0, i);
    cyc("full_done", 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 0);
    idle("full_after");

    // A write to entry 1 while busy must be dropped.
    load_base();
    cyc("wbusy_e0", 1'b1, 1'b0, 1'b0, 6'h08, 1'b1, 1'b0, 0);
    prog_we    = 1'b1;
    prog_addr  = 4'd1;
    prog_instr = 6'h3F;
    prog_rep   = '0;
    prog_halt  = 1'b0;
    cyc("wbusy_e1a", 1'b0, 1'b0, 1'b0, 6'h10, 1'b1, 1'b0, 1);
    prog_we = 1'b0;
    cyc("wbusy_e1b", 1'b0, 1'b0, 1'b0, 6'h10, 1'b1, 1'b0, 1);
    cyc("wbusy_e1c", 1'b0, 1'b0, 1'b0, 6'h10, 1'b1, 1'b0, 1);
    cyc("wbusy_e2",  1'b0, 1'b0, 1'b0, 6'h24, 1'b1, 1'b0, 2);
    cyc("wbusy_done", 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 0);
    idle("wbusy_after");
    run_base("readback");

    // Asynchronous reset between edges while running, then replay.
    cyc("arst_e0",  1'b1, 1'b0, 1'b0, 6'h08, 1'b1, 1'b0, 0);
    cyc("arst_e1a", 1'b0, 1'b0, 1'b0, 6'h10, 1'b1, 1'b0, 1);
    expect_obs("arst_async", 6'h00, 1'b0, 1'b0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    cyc("arst_hold", 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 0);
    rst_n = 1'b1;
    idle("arst_release");
    run_base("replay");

    for (int k = 0; k < 10 && exp_q.size() > 0; k++)
      @(negedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got pending=%0d, want pending=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
- Issues the 6-bit control instruction word that the control decoder consumes. It is the producer end of the instruction interface.
- Holds a small program memory. Each entry is an instruction plus a repeat count and a halt flag.
- On start, it steps through the program and drives one instruction per cycle.
- Sits between the host/testbench load path and the control decoder at the TPU top level.

Parameters:
- DEPTH, 16, number of program entries (power of 2, ≥2)
- REP_W, 4, width of the per-entry repeat count
- ADDR_W, $clog2(DEPTH), program address width (derived, not overridden)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous reset, active-low
- prog_we  input  1  program write strobe
- prog_addr  input  ADDR_W  program write address
- prog_instr  input  6  instruction field to store
- prog_rep  input  REP_W  repeat count; entry is emitted rep+1 cycles
- prog_halt  input  1  halt flag; stop after this entry
- start  input  1  single-cycle pulse; begin execution at address 0
- stall  input  1  freeze sequencing and emit NOP
- abort  input  1  terminate program immediately
- instruction  output  6  registered instruction to the decoder
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when the program completes normally
- pc  output  ADDR_W  address of the entry currently being emitted

Behaviour:
- Reset (async, rst_n=0):
  - instruction=0, busy=0, done=0, pc=0, state=IDLE, repeat counter=0.
  - Program memory contents are not reset.
- Instruction bit map, fixed:
  - [1:0] activation datapath select
  - [2] nn_start
  - [3] load_inputs
  - [4] load_weights
  - [5] load_bias
  - 6'b0 is NOP.
- Program write:
  - Takes effect when prog_we=1 in IDLE; the entry is written at the clock edge.
  - prog_we while busy is ignored and memory is unchanged.
- States: IDLE, RUN. done is a registered pulse, not a separate state.
- IDLE:
  - instruction=0.
  - start=1 → RUN, pc=0, repeat counter loaded with mem[0].rep.
  - instruction=mem[0].instr is registered at the same edge, so it is visible the cycle after start is sampled (latency 1).
- RUN, per cycle with stall=0:
  - If the counter is nonzero: decrement it; instruction and pc are held.
  - If the counter is zero and the entry is terminal: go to IDLE, instruction=0, pulse done=1 for one cycle.
    - Terminal means halt=1, or pc==DEPTH-1 (implicit halt, no wrap-around).
  - Otherwise: pc+1, load the counter with the new entry's rep, instruction=new entry's instr.
- Stall in RUN:
  - instruction=0, pc and counter frozen.
  - On stall deassert, the held entry resumes with its remaining count. The registered output restores the instruction one cycle after stall falls.
  - Stalled cycles do not count toward repeats.
- Abort:
  - In RUN: abort=1 has highest priority → IDLE, instruction=0, busy=0, no done pulse.
  - In IDLE: abort=1 has no effect.
- Simultaneous events:
  - start in RUN is ignored.
  - start together with abort in IDLE: abort wins, state stays IDLE.
  - start together with stall in IDLE: enter RUN with pc=0, but instruction=0 until stall falls.
- Outputs:
  - busy = (state==RUN), registered.
  - done never coincides with busy=1.
- Mid-operation reset: rst_n low in any state forces the reset values immediately, without waiting for a clock edge.
- Total emitted instruction cycles, without stall, equals Σ(rep_i+1) over the executed entries.

Decomposition:
- tpu_ctrl_pkg:
  - INSTR_W=6.
  - Bit-index constants: ACT_LO=0, ACT_HI=1, NN_START=2, LOAD_INPUTS=3, LOAD_WEIGHTS=4, LOAD_BIAS=5.
  - INSTR_NOP=6'b0.
  - Typedef prog_entry_t as a packed struct {halt, rep, instr}.
  - seq_state_t enum {IDLE, RUN}.
- One sub-module, seq_prog_mem:
  - DEPTH×prog_entry_t register array.
  - Synchronous write, combinational read.
  - No reset on contents.
- The FSM, repeat counter and output register stay in the top module.

Test Plan:
- Load mem[0]={halt=0,rep=0,instr=6'h08}, mem[1]={halt=0,rep=2,instr=6'h10}, mem[2]={halt=1,rep=0,instr=6'h24}; pulse start → instruction 08,10,10,10,24 over 5 consecutive cycles, then 00 with done=1 for 1 cycle; busy high exactly 5 cycles.
- Same program; assert stall for 3 cycles while instr 10 has 1 repeat left → 3 cycles of 00, pc held at 1, then 10 once more, then 24; total non-NOP cycles still 5.
- Assert abort on the 2nd cycle of entry 1 → next cycle instruction=00, busy=0, pc=0, and done never pulses.
- No halt bits set, DEPTH=16, all rep=0, instr=pc-indexed pattern → 16 instructions emitted, then done=1 after pc=15; pc never wraps to 0 while busy.
- Drive prog_we to mem[1] with 6'h3F while busy → readback run after completion still emits 6'h10 for entry 1.
- Assert rst_n=0 asynchronously mid-RUN (between edges) → instruction=00, busy=0, pc=0 before the next clock edge; a fresh start replays the program unchanged.
